perceptron_sample_loader: RTL and testbench
===========================================

# perceptron_sample_loader

Upstream feeder for the perceptron trainer. It accepts training bytes one at a time from the chip's byte-wide input pins and assembles them into samples in an internal buffer. On command it streams the buffered samples to the trainer over a valid/ready handshake, repeating the whole set for a fixed number of epochs. The trainer consumes each (features, label) pair and no longer needs hard-coded `initial` data.

## Interface
Parameters:
- `INP_N_SAMPLES`, 3: samples held in the buffer.
- `INP_DIM`, 2: features per sample.
- `N_EPOCHS`, 4: full passes over the buffer per start; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input byte present on `in_data`.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `start`  in  1  single-cycle pulse that begins streaming.
- `clear`  in  1  single-cycle pulse that discards the buffer and returns to loading.
- `smp_valid`  out  1  a sample is presented to the trainer.
- `smp_ready`  in  1  trainer accepts the presented sample.
- `smp_x`  out  4*INP_DIM  packed features; feature d occupies bits [4d+3:4d].
- `smp_y`  out  1  sample label.
- `smp_idx`  out  clog2(INP_N_SAMPLES)  index of the presented sample.
- `smp_last`  out  1  presented sample is the last one of the last epoch.
- `epoch`  out  clog2(N_EPOCHS+1)  number of epochs fully completed.
- `busy`  out  1  streaming is in progress.
- `done`  out  1  all epochs have been delivered.

## Operation
- State machine states: LOAD, FULL, STREAM, DONE. Reset and `clear` both enter LOAD.
- **Byte format.** Each sample is INP_DIM+1 bytes, in this order: feature 0 … feature INP_DIM-1, then the label.
  - Feature bytes: only the low nibble is stored; the high nibble is ignored.
  - Label byte: only bit 0 is stored.
- **LOAD.**
  - `in_ready`=1.
  - A byte is accepted on each cycle with `in_valid`&&`in_ready`.
  - Byte counter and sample counter advance with each accepted byte.
  - Acceptance of byte number INP_N_SAMPLES*(INP_DIM+1) moves the state to FULL.
- **FULL.**
  - `in_ready`=0; input bytes are ignored.
  - `start` moves the state to STREAM with sample index 0 and `epoch`=0.
- **STREAM.**
  - `smp_valid`=1 and `busy`=1.
  - Outputs show buffer[index].
  - A transfer occurs when `smp_valid`&&`smp_ready`.
  - Index increments on each transfer. After index INP_N_SAMPLES-1 it wraps to 0 and `epoch` increments.
  - A transfer that completes epoch N_EPOCHS moves the state to DONE.
- **DONE.**
  - `done`=1, `smp_valid`=0.
  - The buffer is retained.
  - `start` re-enters STREAM with `epoch`=0 and index 0.
- **Command priority.** `clear` beats `start`. `start` is ignored in LOAD and STREAM.
- **Output stability.** While `smp_valid`=1 and `smp_ready`=0, `smp_x`, `smp_y`, `smp_idx` and `smp_last` are held stable.
- **`smp_last`** = 1 when in STREAM, index is INP_N_SAMPLES-1, and `epoch`=N_EPOCHS-1.

## Timing
- **Reset values.**
  - State = LOAD; all counters = 0.
  - `in_ready`=1, `smp_valid`=0, `smp_x`=0, `smp_y`=0, `smp_idx`=0, `smp_last`=0, `epoch`=0, `busy`=0, `done`=0.
  - Buffer contents after reset are don't-care.
- **Output timing.**
  - `smp_*`, `busy` and `done` are registered.
  - `in_ready` is decoded directly from the state.
- **Last byte.** Accepting the last byte at edge k gives `in_ready`=0 from cycle k+1.
- **Start.** `start` sampled at edge k gives `smp_valid`=1 with sample 0 in cycle k+1.
- **Back-to-back.** With `smp_ready` held at 1, a new sample is presented every cycle with no bubbles. This includes epoch wrap.
  - Total: INP_N_SAMPLES*N_EPOCHS valid cycles from start to DONE.
- **Final transfer** at edge k gives `smp_valid`=0 and `done`=1 in cycle k+1, and `epoch`=N_EPOCHS.
- **Clear** at edge k gives state LOAD and `in_ready`=1 in cycle k+1, with `busy`=`done`=`smp_valid`=0.
  - A byte presented together with `clear` is dropped.
- **Reset mid-operation.**
  - Asserting `rst` in any state forces the reset values immediately, without waiting for a clock edge.
  - After release, loading restarts from byte 0.
- **Stalls.** `smp_ready`=0 may be held indefinitely. No timeout applies.

## Test plan
- **Load and stream.**
  - Stimulus: after reset, feed bytes 02 03 00 04 05 01 01 02 01 with `in_valid` held at 1, then pulse `start`, with `smp_ready`=1.
  - Required: `in_ready` drops after the 9th byte.
  - Then 12 consecutive valid cycles with `smp_x`/`smp_y` = 32/0, 54/1, 21/1, repeating. `smp_idx` runs 0,1,2,…
  - `smp_last` is high only on the 12th cycle; `done`=1 and `epoch`=4 afterwards.
- **Nibble and label masking.**
  - Stimulus: bytes F2 A3 FE for sample 0.
  - Required: `smp_x`=32, `smp_y`=0.
- **Backpressure.**
  - Stimulus: toggle `smp_ready` 1,0,0,1,… during streaming.
  - Required: `smp_*` stable while stalled; no sample is lost or duplicated; same 12-sample order.
- **Commands.**
  - `start` issued during LOAD (after 4 bytes): ignored, and loading continues.
  - `clear` and `start` in the same cycle in FULL: state goes to LOAD, `in_ready`=1, no `smp_valid`.
- **Retrain.**
  - Stimulus: `start` in DONE.
  - Required: the full 12-sample stream repeats from index 0 with `epoch` reset to 0.
- **Asynchronous reset.**
  - Stimulus: assert `rst` between clock edges during epoch 2 of STREAM.
  - Required: `smp_valid`, `busy` and `epoch` go to 0 without a clock edge. After release, `in_ready`=1 and a new 9-byte load is required.

Source files
------------

// File: rtl/perceptron_sample_loader.sv
// Byte-serial sample loader for the perceptron trainer: assembles training bytes into a sample
// buffer, then replays the buffer over a valid/ready stream for a fixed number of epochs.
module perceptron_sample_loader #(
  parameter int unsigned INP_N_SAMPLES = 3,
  parameter int unsigned INP_DIM       = 2,
  parameter int unsigned N_EPOCHS      = 4,
  localparam int unsigned IdxW  = (INP_N_SAMPLES > 1) ? $clog2(INP_N_SAMPLES) : 1,
  localparam int unsigned EpW   = $clog2(N_EPOCHS + 1),
  localparam int unsigned FeatW = $clog2(INP_DIM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 start,
  input  logic                 clear,
  output logic                 smp_valid,
  input  logic                 smp_ready,
  output logic [4*INP_DIM-1:0] smp_x,
  output logic                 smp_y,
  output logic [IdxW-1:0]      smp_idx,
  output logic                 smp_last,
  output logic [EpW-1:0]       epoch,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StLoad, StFull, StStream, StDone} state_e;

  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(INP_N_SAMPLES - 1);
  localparam logic [EpW-1:0]   LastEpoch = EpW'(N_EPOCHS - 1);
  localparam logic [FeatW-1:0] LabelPos  = FeatW'(INP_DIM);

  state_e               state_q, state_d;
  logic [FeatW-1:0]     feat_q, feat_d;
  logic [IdxW-1:0]      wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]      rd_idx_q, rd_idx_d;
  logic [EpW-1:0]       epoch_q, epoch_d;
  logic [4*INP_DIM-1:0] x_buf_q [INP_N_SAMPLES];
  logic [INP_N_SAMPLES-1:0] y_buf_q;
  logic                 accept;

  logic                 smp_valid_q, smp_valid_d;
  logic [4*INP_DIM-1:0] smp_x_q, smp_x_d;
  logic                 smp_y_q, smp_y_d;
  logic [IdxW-1:0]      smp_idx_q, smp_idx_d;
  logic                 smp_last_q, smp_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // High nibble of each byte is never stored.
  logic unused_in_hi;
  assign unused_in_hi = ^in_data[7:4];

  assign in_ready = (state_q == StLoad);
  // A byte that arrives together with clear is dropped.
  assign accept   = in_valid && in_ready && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      feat_q   <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      epoch_q  <= '0;
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      epoch_q  <= epoch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    feat_d   = feat_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    epoch_d  = epoch_q;
    if (clear) begin
      state_d  = StLoad;
      feat_d   = '0;
      wr_idx_d = '0;
      rd_idx_d = '0;
      epoch_d  = '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            if (feat_q == LabelPos) begin
              feat_d = '0;
              if (wr_idx_q == LastIdx) begin
                wr_idx_d = '0;
                state_d  = StFull;
              end else begin
                wr_idx_d = wr_idx_q + IdxW'(1);
              end
            end else begin
              feat_d = feat_q + FeatW'(1);
            end
          end
        end
        StFull, StDone: begin
          if (start) begin
            state_d  = StStream;
            rd_idx_d = '0;
            epoch_d  = '0;
          end
        end
        StStream: begin
          if (smp_ready) begin
            if (rd_idx_q == LastIdx) begin
              rd_idx_d = '0;
              epoch_d  = epoch_q + EpW'(1);
              if (epoch_q == LastEpoch) state_d = StDone;
            end else begin
              rd_idx_d = rd_idx_q + IdxW'(1);
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  // Sample storage carries no reset; its contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (feat_q == LabelPos) y_buf_q[wr_idx_q] <= in_data[0];
      for (int d = 0; d < int'(INP_DIM); d++) begin
        if (feat_q == FeatW'(d)) x_buf_q[wr_idx_q][4*d +: 4] <= in_data[3:0];
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    smp_valid_d = (state_d == StStream);
    busy_d      = (state_d == StStream);
    done_d      = (state_d == StDone);
    smp_x_d     = smp_x_q;
    smp_y_d     = smp_y_q;
    smp_idx_d   = smp_idx_q;
    if (state_d == StStream) begin
      smp_x_d   = x_buf_q[rd_idx_d];
      smp_y_d   = y_buf_q[rd_idx_d];
      smp_idx_d = rd_idx_d;
    end else if (state_d == StLoad) begin
      smp_x_d   = '0;
      smp_y_d   = 1'b0;
      smp_idx_d = '0;
    end
    smp_last_d = (state_d == StStream) && (rd_idx_d == LastIdx) && (epoch_d == LastEpoch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_valid_q <= 1'b0;
      smp_x_q     <= '0;
      smp_y_q     <= 1'b0;
      smp_idx_q   <= '0;
      smp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      smp_valid_q <= smp_valid_d;
      smp_x_q     <= smp_x_d;
      smp_y_q     <= smp_y_d;
      smp_idx_q   <= smp_idx_d;
      smp_last_q  <= smp_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign smp_valid = smp_valid_q;
  assign smp_x     = smp_x_q;
  assign smp_y     = smp_y_q;
  assign smp_idx   = smp_idx_q;
  assign smp_last  = smp_last_q;
  assign epoch     = epoch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Bench for perceptron_sample_loader: loads byte streams, replays them and compares every
// presented sample against a simple array/arithmetic model of the buffer and epoch order.
module tb_perceptron_sample_loader;

  localparam int NS    = 3;
  localparam int DIM   = 2;
  localparam int NE    = 4;
  localparam int BPS   = DIM + 1;
  localparam int NB    = NS * BPS;
  localparam int TOTAL = NS * NE;
  localparam int IW    = $clog2(NS);
  localparam int EW    = $clog2(NE + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           start;
  logic           clear;
  logic           smp_valid;
  logic           smp_ready;
  logic [4*DIM-1:0] smp_x;
  logic           smp_y;
  logic [IW-1:0]  smp_idx;
  logic           smp_last;
  logic [EW-1:0]  epoch;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] bytes_m [NB];

  perceptron_sample_loader #(
    .INP_N_SAMPLES(NS),
    .INP_DIM      (DIM),
    .N_EPOCHS     (NE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .start    (start),
    .clear    (clear),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .smp_x    (smp_x),
    .smp_y    (smp_y),
    .smp_idx  (smp_idx),
    .smp_last (smp_last),
    .epoch    (epoch),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Model: features are the low nibbles of the first DIM bytes, label is bit 0 of the last.
  function automatic logic [4*DIM-1:0] exp_x(input int s);
    logic [4*DIM-1:0] r;
    logic [7:0] b;
    r = '0;
    for (int d = 0; d < DIM; d++) begin
      b = bytes_m[s*BPS + d];
      r[4*d +: 4] = b[3:0];
    end
    return r;
  endfunction

  function automatic logic exp_y(input int s);
    logic [7:0] b;
    b = bytes_m[s*BPS + DIM];
    return b[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_bytes();
    for (int i = 0; i < NB; i++) bytes_m[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic load_range(input int lo, input int hi, input bit gaps);
    for (int i = lo; i < hi; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_data  = bytes_m[i];
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready byte %0d: in_ready=%b required 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    if (hi == NB) begin
      n_checks++;
      if (in_ready !== 1'b0 || smp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL full_ready: in_ready=%b smp_valid=%b required 0 0", in_ready, smp_valid);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready.
  task automatic run_stream(input int mode, input string tag);
    int n = 0;
    int cyc = 0;
    logic r;
    logic stalled = 1'b0;
    logic [4*DIM-1:0] px;
    logic py;
    logic [IW-1:0] pidx;
    logic plast;
    while (n < TOTAL && cyc < 400) begin
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (cyc % 3 == 0);
      else r = 1'($urandom_range(0, 1));
      smp_ready = r;
      n_checks++;
      if (smp_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_valid n=%0d: valid=%b busy=%b done=%b required 1 1 0",
                 tag, n, smp_valid, busy, done);
      end
      n_checks++;
      if (smp_x !== exp_x(n % NS) || smp_y !== exp_y(n % NS) || smp_idx !== IW'(n % NS) ||
          smp_last !== (n == TOTAL - 1) || epoch !== EW'(n / NS)) begin
        n_fail++;
        $display("FAIL %s_sample n=%0d: x=%h y=%b idx=%0d last=%b ep=%0d required %h %b %0d %b %0d",
                 tag, n, smp_x, smp_y, smp_idx, smp_last, epoch, exp_x(n % NS), exp_y(n % NS),
                 n % NS, (n == TOTAL - 1), n / NS);
      end
      if (stalled) begin
        n_checks++;
        if (smp_x !== px || smp_y !== py || smp_idx !== pidx || smp_last !== plast) begin
          n_fail++;
          $display("FAIL %s_stall n=%0d: x=%h idx=%0d required held %h %0d",
                   tag, n, smp_x, smp_idx, px, pidx);
        end
      end
      px = smp_x; py = smp_y; pidx = smp_idx; plast = smp_last;
      stalled = !r;
      tick();
      if (r) n++;
      cyc++;
    end
    smp_ready = 1'b0;
    n_checks++;
    if (n != TOTAL) begin
      n_fail++;
      $display("FAIL %s_timeout: transfers=%0d required %0d", tag, n, TOTAL);
    end
    if (mode == 0) begin
      n_checks++;
      if (cyc != TOTAL) begin
        n_fail++;
        $display("FAIL %s_bubbles: cycles=%0d required %0d", tag, cyc, TOTAL);
      end
    end
    n_checks++;
    if (smp_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || epoch !== EW'(NE)) begin
      n_fail++;
      $display("FAIL %s_done: valid=%b done=%b busy=%b epoch=%0d required 0 1 0 %0d",
               tag, smp_valid, done, busy, epoch, NE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || smp_valid !== 1'b0 || smp_x !== '0 || smp_y !== 1'b0 ||
        smp_idx !== '0 || smp_last !== 1'b0 || epoch !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b v=%b x=%h y=%b idx=%0d last=%b ep=%0d busy=%b done=%b",
               in_ready, smp_valid, smp_x, smp_y, smp_idx, smp_last, epoch, busy, done);
    end
    #10;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_stream();
    logic [7:0] plan [NB];
    plan = '{8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h01, 8'h01, 8'h02, 8'h01};
    bytes_m = plan;
    load_range(0, NB, 1'b0);
    pulse_start();
    n_checks++;
    if (smp_x !== 8'h32 || smp_y !== 1'b0) begin
      n_fail++;
      $display("FAIL plan_first: x=%h y=%b required 32 0", smp_x, smp_y);
    end
    smp_ready = 1'b1;
    run_stream(0, "plan");
  endtask

  task automatic test_masking();
    pulse_clear();
    randomize_bytes();
    bytes_m[0] = 8'hF2;
    bytes_m[1] = 8'hA3;
    bytes_m[2] = 8'hFE;
    load_range(0, NB, 1'b1);
    pulse_start();
    n_checks++;
    if (smp_x !== 8'h32 || smp_y !== 1'b0 || smp_idx !== '0) begin
      n_fail++;
      $display("FAIL mask: x=%h y=%b idx=%0d required 32 0 0", smp_x, smp_y, smp_idx);
    end
    run_stream(2, "mask");
  endtask

  task automatic test_backpressure();
    pulse_clear();
    randomize_bytes();
    load_range(0, NB, 1'b1);
    pulse_start();
    run_stream(1, "bp_pattern");
    pulse_start();
    run_stream(2, "bp_random");
  endtask

  task automatic test_commands();
    pulse_clear();
    randomize_bytes();
    load_range(0, 4, 1'b0);
    pulse_start();
    n_checks++;
    if (smp_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_load: valid=%b busy=%b rdy=%b required 0 0 1",
               smp_valid, busy, in_ready);
    end
    load_range(4, NB, 1'b0);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || smp_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_beats_start: rdy=%b valid=%b busy=%b done=%b required 1 0 0 0",
               in_ready, smp_valid, busy, done);
    end
    // A byte offered with clear must not shift the following load.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    randomize_bytes();
    load_range(0, NB, 1'b0);
    pulse_start();
    run_stream(2, "after_clear");
  endtask

  task automatic test_retrain();
    pulse_start();
    run_stream(0, "retrain");
  endtask

  task automatic test_async_reset();
    int k = 0;
    pulse_clear();
    randomize_bytes();
    load_range(0, NB, 1'b0);
    pulse_start();
    smp_ready = 1'b1;
    while (epoch !== EW'(2) && k < 50) begin
      tick();
      k++;
    end
    n_checks++;
    if (epoch !== EW'(2) || smp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_reach_epoch2: epoch=%0d valid=%b required 2 1", epoch, smp_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (smp_valid !== 1'b0 || busy !== 1'b0 || epoch !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_immediate: valid=%b busy=%b epoch=%0d rdy=%b required 0 0 0 1",
               smp_valid, busy, epoch, in_ready);
    end
    smp_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || smp_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: rdy=%b valid=%b done=%b required 1 0 0",
               in_ready, smp_valid, done);
    end
    randomize_bytes();
    load_range(0, NB - 1, 1'b0);
    pulse_start();
    n_checks++;
    if (smp_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_reload: valid=%b rdy=%b required 0 1 after %0d bytes",
               smp_valid, in_ready, NB - 1);
    end
    load_range(NB - 1, NB, 1'b0);
    pulse_start();
    run_stream(2, "areset_stream");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    start     = 1'b0;
    clear     = 1'b0;
    smp_ready = 1'b0;
    test_reset();
    test_load_stream();
    test_masking();
    test_backpressure();
    test_commands();
    test_retrain();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
